// File: rtl/soc_cpu_debug_vjtag_host_if.sv
// Command/response bus between a debug client and the virtual-JTAG host.
interface soc_cpu_debug_vjtag_host_if #(
    parameter int unsigned IR_WIDTH = 2,
    parameter int unsigned DR_WIDTH = 38
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_skip_ir;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_data;
    logic [IR_WIDTH-1:0] rsp_ir;
    logic                busy;

    modport master (
        output cmd_valid, cmd_skip_ir, cmd_ir, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir, busy
    );

    modport slave (
        input  cmd_valid, cmd_skip_ir, cmd_ir, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir, busy
    );
endinterface

// File: rtl/soc_cpu_debug_vjtag_host.sv
// Nios II virtual-JTAG debug host: turns one IR/DR command into a
// UIR -> CDR -> SDR -> UDR -> RTI sequence on a generated tck.
module soc_cpu_debug_vjtag_host #(
    parameter int unsigned IR_WIDTH    = 2,
    parameter int unsigned DR_WIDTH    = 38,
    parameter int unsigned TCK_HALF    = 2,
    parameter int unsigned RTI_PERIODS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    soc_cpu_debug_vjtag_host_if.slave   host,
    output logic                        vji_tck,
    output logic                        vji_tdi,
    input  logic                        vji_tdo,
    output logic [IR_WIDTH-1:0]         vji_ir_in,
    input  logic [IR_WIDTH-1:0]         vji_ir_out,
    output logic                        vji_uir,
    output logic                        vji_cdr,
    output logic                        vji_sdr,
    output logic                        vji_udr,
    output logic                        vji_rti
);
    localparam int unsigned PER_MAX = (DR_WIDTH > RTI_PERIODS) ? DR_WIDTH : RTI_PERIODS;
    localparam int unsigned PER_W   = $clog2(PER_MAX);
    localparam int unsigned CNT_W   = $clog2(2 * TCK_HALF);

    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(TCK_HALF - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(2 * TCK_HALF - 1);
    localparam logic [PER_W-1:0] SDR_LAST  = PER_W'(DR_WIDTH - 1);
    localparam logic [PER_W-1:0] RTI_LAST  = PER_W'(RTI_PERIODS - 1);

    // Strobe vector order: {uir, cdr, sdr, udr, rti}
    localparam logic [4:0] STB_NONE = 5'b00000;
    localparam logic [4:0] STB_UIR  = 5'b10000;
    localparam logic [4:0] STB_CDR  = 5'b01000;
    localparam logic [4:0] STB_SDR  = 5'b00100;
    localparam logic [4:0] STB_UDR  = 5'b00010;
    localparam logic [4:0] STB_RTI  = 5'b00001;

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PER_W-1:0]    per_q;
    logic [DR_WIDTH-1:0] sh_q;
    logic [DR_WIDTH-1:0] cap_q;
    logic [DR_WIDTH-1:0] rsp_data_q;
    logic [IR_WIDTH-1:0] ir_in_q;
    logic [IR_WIDTH-1:0] rsp_ir_q;
    logic [4:0]          stb_q;
    logic                tck_q;
    logic                tdi_q;
    logic                ready_q;
    logic                busy_q;
    logic                rsp_valid_q;

    // cnt_q walks one tck period: low phase 0..LOW_LAST, high phase up to HIGH_LAST
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            per_q       <= '0;
            sh_q        <= '0;
            cap_q       <= '0;
            rsp_data_q  <= '0;
            ir_in_q     <= '0;
            rsp_ir_q    <= '0;
            stb_q       <= STB_NONE;
            tck_q       <= 1'b0;
            tdi_q       <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (host.cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        sh_q    <= host.cmd_data;
                        cnt_q   <= '0;
                        per_q   <= '0;
                        if (host.cmd_skip_ir) begin
                            state_q <= S_CDR;
                            stb_q   <= STB_CDR;
                        end else begin
                            state_q <= S_UIR;
                            stb_q   <= STB_UIR;
                            ir_in_q <= host.cmd_ir;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    // tdo is taken in the last low clk, just before tck rises
                    if (cnt_q == LOW_LAST) begin
                        tck_q <= 1'b1;
                        if (state_q == S_SDR) begin
                            cap_q <= {vji_tdo, cap_q[DR_WIDTH-1:1]};
                        end
                    end
                    if (cnt_q == HIGH_LAST) begin
                        cnt_q <= '0;
                        tck_q <= 1'b0;
                        case (state_q)
                            S_UIR: begin
                                rsp_ir_q <= vji_ir_out;
                                state_q  <= S_CDR;
                                stb_q    <= STB_CDR;
                            end
                            S_CDR: begin
                                state_q <= S_SDR;
                                stb_q   <= STB_SDR;
                                per_q   <= '0;
                                tdi_q   <= sh_q[0];
                            end
                            S_SDR: begin
                                sh_q <= {1'b0, sh_q[DR_WIDTH-1:1]};
                                if (per_q == SDR_LAST) begin
                                    state_q <= S_UDR;
                                    stb_q   <= STB_UDR;
                                    tdi_q   <= 1'b0;
                                end else begin
                                    per_q <= per_q + PER_W'(1);
                                    tdi_q <= sh_q[1];
                                end
                            end
                            S_UDR: begin
                                state_q <= S_RTI;
                                stb_q   <= STB_RTI;
                                per_q   <= '0;
                            end
                            S_RTI: begin
                                if (per_q == RTI_LAST) begin
                                    state_q     <= S_DONE;
                                    stb_q       <= STB_NONE;
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= cap_q;
                                end else begin
                                    per_q <= per_q + PER_W'(1);
                                end
                            end
                            default: begin
                                state_q <= S_IDLE;
                                stb_q   <= STB_NONE;
                            end
                        endcase
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign host.cmd_ready = ready_q;
    assign host.busy      = busy_q;
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_ir    = rsp_ir_q;

    assign vji_tck   = tck_q;
    assign vji_tdi   = tdi_q;
    assign vji_ir_in = ir_in_q;
    assign {vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti} = stb_q;
endmodule
